// File: rtl/note_frame_serializer.sv
// note_frame_serializer
// Transmit side of the note serial link. A handshake fills a pending buffer;
// at each frame start the pending word (if any) moves into the shadow buffer,
// which is shifted out LSB first, one bit per BIT_DIV clocks, with sync high
// during bit 0. GAP_BITS idle slots follow each frame. The shadow word is
// resent every frame until a new word replaces it.
module note_frame_serializer #(
  parameter int NUM_NOTES = 48,
  parameter int BIT_DIV   = 128,
  parameter int GAP_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_NOTES-1:0] notes_in,
  input  logic                 notes_valid,
  output logic                 notes_ready,
  output logic                 note_serial_sync,
  output logic                 note_serial_data,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int IW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [IW-1:0] BIT_LAST = IW'(NUM_NOTES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(BIT_DIV - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_NOTES-1:0]   pend_q, pend_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [NUM_NOTES-1:0]   shadow_q, shadow_d;
  logic [IW-1:0]          bit_idx_q, bit_idx_d;
  logic [DW-1:0]          div_q, div_d;
  logic [GW-1:0]          gap_idx_q, gap_idx_d;
  logic                   sync_q, sync_d;
  logic                   data_q, data_d;
  logic                   frame_done_q, frame_done_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;

  logic                   tick;
  logic                   load;
  logic                   accept;
  logic [IW-1:0]          bit_nxt;

  // Next-state, buffer handshake and registered-output computation.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    shadow_d     = shadow_q;
    bit_idx_d    = bit_idx_q;
    div_d        = div_q;
    gap_idx_d    = gap_idx_q;
    sync_d       = sync_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    tick         = (div_q == DIV_LAST);
    accept       = notes_valid && !pend_valid_q;
    bit_nxt      = bit_idx_q + IW'(1);

    case (state_q)
      IDLE: begin
        div_d  = '0;
        sync_d = 1'b0;
        data_d = 1'b0;
        if (enable) begin
          load = 1'b1;
        end
      end

      SHIFT: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (tick) begin
          sync_d = 1'b0;
          if (bit_idx_q == BIT_LAST) begin
            state_d   = GAP;
            data_d    = 1'b0;
            gap_idx_d = '0;
          end else begin
            bit_idx_d = bit_nxt;
            data_d    = shadow_q[bit_nxt];
          end
        end
      end

      GAP: begin
        div_d  = tick ? '0 : div_q + DW'(1);
        sync_d = 1'b0;
        data_d = 1'b0;
        // Pulse lands on the final clock of the gap, one cycle before the turn.
        if ((gap_idx_q == GAP_LAST) && (div_q == DIV_PRE)) begin
          frame_done_d = 1'b1;
        end
        if (tick) begin
          if (gap_idx_q == GAP_LAST) begin
            if (enable) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_idx_d = gap_idx_q + GW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        sync_d  = 1'b0;
        data_d  = 1'b0;
        div_d   = '0;
      end
    endcase

    // Frame start: promote pending into shadow and present bit 0 with sync.
    if (load) begin
      state_d   = SHIFT;
      bit_idx_d = '0;
      div_d     = '0;
      sync_d    = 1'b1;
      if (pend_valid_q) begin
        shadow_d     = pend_q;
        pend_valid_d = 1'b0;
        data_d       = pend_q[0];
      end else begin
        data_d = shadow_q[0];
      end
    end

    // A word can only be taken while pending is empty, so it never collides
    // with the promotion above; a word taken on a load edge waits a frame.
    if (accept) begin
      pend_d       = notes_in;
      pend_valid_d = 1'b1;
    end

    ready_d = !pend_valid_d;
    busy_d  = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      shadow_q     <= '0;
      bit_idx_q    <= '0;
      div_q        <= '0;
      gap_idx_q    <= '0;
      sync_q       <= 1'b0;
      data_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      shadow_q     <= shadow_d;
      bit_idx_q    <= bit_idx_d;
      div_q        <= div_d;
      gap_idx_q    <= gap_idx_d;
      sync_q       <= sync_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign notes_ready      = ready_q;
  assign note_serial_sync = sync_q;
  assign note_serial_data = data_q;
  assign frame_done       = frame_done_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_note_frame_serializer.sv
// Testbench for note_frame_serializer: frames are observed cycle by cycle and
// judged against the link rules (slot timing, sync, gap, frame_done, buffering).
module tb_note_frame_serializer;

  localparam int N     = 48;
  localparam int D     = 128;
  localparam int G     = 4;
  localparam int FRAME = (N + G) * D;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] notes_in = '0;
  logic         notes_valid = 1'b0;
  logic         notes_ready;
  logic         note_serial_sync;
  logic         note_serial_data;
  logic         frame_done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] x_word, y_word, z_word;

  note_frame_serializer #(.NUM_NOTES(N), .BIT_DIV(D), .GAP_BITS(G)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .notes_in         (notes_in),
    .notes_valid      (notes_valid),
    .notes_ready      (notes_ready),
    .note_serial_sync (note_serial_sync),
    .note_serial_data (note_serial_data),
    .frame_done       (frame_done),
    .busy             (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [N-1:0] rand48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[N-1:0];
  endfunction

  // Observes one frame. With skip_wait=0 it waits for the sync rise (frame
  // cycle 1); otherwise the caller is at the negedge of cycle k_first-1.
  // Returns the word sampled mid-slot, sync-high count inside slot 0, a count
  // of rule breaks (stray sync, unstable slot data, gap data, busy low, X on
  // frame_done) and the cycle of the frame_done pulse (negative count if not
  // exactly one pulse).
  task automatic capture_frame(input bit skip_wait, input int k_first,
                               output bit timed_out, output int wait_cycles,
                               output logic [N-1:0] word, output int sync_hi,
                               output int glitches, output int fd_pos);
    int   fd_count;
    int   k0;
    int   slot;
    int   pos;
    logic cur;
    bit   have;
    timed_out = 1'b0; wait_cycles = 0; word = '0; sync_hi = 0;
    glitches = 0; fd_pos = 0; fd_count = 0; cur = 1'b0; have = 1'b0;
    k0 = k_first;
    if (!skip_wait) begin
      timed_out = 1'b1;
      for (int w = 1; w <= 2 * FRAME; w++) begin
        @(negedge clk);
        if (note_serial_sync === 1'b1) begin
          wait_cycles = w;
          timed_out   = 1'b0;
          break;
        end
      end
      if (timed_out) return;
      k0   = 1;
      have = 1'b1;
    end
    for (int k = k0; k <= FRAME; k++) begin
      if (!have) @(negedge clk);
      have = 1'b0;
      slot = (k - 1) / D;
      pos  = (k - 1) % D;
      if (note_serial_sync === 1'b1) begin
        if (k <= D) sync_hi++;
        else glitches++;
      end
      if (busy !== 1'b1) glitches++;
      if (slot < N) begin
        if (k == k0 || pos == 0) cur = note_serial_data;
        else if (note_serial_data !== cur) glitches++;
        if (pos == D / 2) word[slot] = note_serial_data;
      end else if (note_serial_data !== 1'b0) begin
        glitches++;
      end
      if (frame_done === 1'b1) begin
        fd_count++;
        fd_pos = k;
      end else if (frame_done !== 1'b0) begin
        glitches++;
      end
    end
    if (fd_count != 1) fd_pos = -fd_count;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; notes_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (note_serial_sync !== 1'b0) begin errors++; $display("[TB] FAIL rst_sync got %b exp 0", note_serial_sync); end
    checks++; if (note_serial_data !== 1'b0) begin errors++; $display("[TB] FAIL rst_data got %b exp 0", note_serial_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done got %b exp 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", busy); end
    checks++; if (notes_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %b exp 1", notes_ready); end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0 || note_serial_sync !== 1'b0) begin errors++; $display("[TB] FAIL rst_hold_idle got busy=%b sync=%b exp 0 0", busy, note_serial_sync); end
  endtask

  task automatic test_single_bit();
    bit           to;
    int           wc, sh, gl, fp;
    logic [N-1:0] w;
    logic [N-1:0] exp_w;
    exp_w = 48'h1;
    @(negedge clk); notes_in = exp_w; notes_valid = 1'b1;
    @(negedge clk); notes_valid = 1'b0; enable = 1'b1;
    checks++; if (notes_ready !== 1'b0) begin errors++; $display("[TB] FAIL t2_ready_pending got %b exp 0", notes_ready); end
    capture_frame(1'b0, 0, to, wc, w, sh, gl, fp);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL t2_f1_timeout got %b exp 0", to); end
    checks++; if (w !== exp_w) begin errors++; $display("[TB] FAIL t2_f1_word got %h exp %h", w, exp_w); end
    checks++; if (sh !== D) begin errors++; $display("[TB] FAIL t2_sync_len got %0d exp %0d", sh, D); end
    checks++; if (gl !== 0) begin errors++; $display("[TB] FAIL t2_f1_glitches got %0d exp 0", gl); end
    checks++; if (fp !== FRAME) begin errors++; $display("[TB] FAIL t2_frame_done_pos got %0d exp %0d", fp, FRAME); end
    capture_frame(1'b0, 0, to, wc, w, sh, gl, fp);
    checks++; if (wc !== 1) begin errors++; $display("[TB] FAIL t2_period got %0d exp %0d", FRAME + wc - 1, FRAME); end
    checks++; if (w !== exp_w) begin errors++; $display("[TB] FAIL t2_f2_word got %h exp %h", w, exp_w); end
    checks++; if (fp !== FRAME || gl !== 0) begin errors++; $display("[TB] FAIL t2_f2_shape got fd=%0d gl=%0d exp %0d 0", fp, gl, FRAME); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || notes_ready !== 1'b1) begin errors++; $display("[TB] FAIL t2_idle got busy=%b ready=%b exp 0 1", busy, notes_ready); end
  endtask

  task automatic test_pattern();
    bit           to;
    int           wc, sh, gl, fp;
    logic [N-1:0] w;
    logic [N-1:0] exp_w;
    exp_w = 48'hA5A5_0F0F_F00F;
    @(negedge clk); notes_in = exp_w; notes_valid = 1'b1;
    @(negedge clk); notes_valid = 1'b0; enable = 1'b1;
    capture_frame(1'b0, 0, to, wc, w, sh, gl, fp);
    checks++; if (w !== exp_w) begin errors++; $display("[TB] FAIL t3_f1_word got %h exp %h", w, exp_w); end
    checks++; if (gl !== 0 || sh !== D) begin errors++; $display("[TB] FAIL t3_f1_shape got gl=%0d sync=%0d exp 0 %0d", gl, sh, D); end
    capture_frame(1'b0, 0, to, wc, w, sh, gl, fp);
    checks++; if (wc !== 1) begin errors++; $display("[TB] FAIL t3_gapless got %0d exp 1", wc); end
    checks++; if (w !== exp_w) begin errors++; $display("[TB] FAIL t3_repeat_word got %h exp %h", w, exp_w); end
    checks++; if (fp !== FRAME) begin errors++; $display("[TB] FAIL t3_f2_frame_done got %0d exp %0d", fp, FRAME); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t3_idle got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit           to, found, got;
    logic         sync_at_ready, ready_after_y;
    int           wc, sh, gl, fp;
    logic [N-1:0] w;
    x_word = rand48();
    y_word = rand48();
    if (y_word == x_word) y_word = ~x_word;
    @(negedge clk); enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (note_serial_sync === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL t4_f0_start got %b exp 1", found); end
    repeat ($urandom_range(3000, 200)) @(negedge clk);
    checks++; if (notes_ready !== 1'b1) begin errors++; $display("[TB] FAIL t4_ready_before_x got %b exp 1", notes_ready); end
    notes_in = x_word; notes_valid = 1'b1;
    @(negedge clk);
    checks++; if (notes_ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_ready_after_x got %b exp 0", notes_ready); end
    notes_in = y_word;
    got = 1'b0; sync_at_ready = 1'b0; ready_after_y = 1'b1;
    fork
      capture_frame(1'b0, 0, to, wc, w, sh, gl, fp);
      begin
        for (int i = 0; i < 2 * FRAME; i++) begin
          @(negedge clk);
          if (notes_ready === 1'b1) begin
            got = 1'b1;
            sync_at_ready = note_serial_sync;
            break;
          end
        end
        @(negedge clk);
        notes_valid = 1'b0;
        ready_after_y = notes_ready;
      end
    join
    checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL t4_ready_return got %b exp 1", got); end
    checks++; if (sync_at_ready !== 1'b1) begin errors++; $display("[TB] FAIL t4_ready_at_load got sync=%b exp 1", sync_at_ready); end
    checks++; if (ready_after_y !== 1'b0) begin errors++; $display("[TB] FAIL t4_y_accepted got ready=%b exp 0", ready_after_y); end
    checks++; if (to !== 1'b0 || w !== x_word) begin errors++; $display("[TB] FAIL t4_f1_word got %h exp %h", w, x_word); end
    checks++; if (gl !== 0 || fp !== FRAME) begin errors++; $display("[TB] FAIL t4_f1_shape got gl=%0d fd=%0d exp 0 %0d", gl, fp, FRAME); end
    capture_frame(1'b0, 0, to, wc, w, sh, gl, fp);
    checks++; if (wc !== 1 || w !== y_word) begin errors++; $display("[TB] FAIL t4_f2_word got %h wait=%0d exp %h 1", w, wc, y_word); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || notes_ready !== 1'b1) begin errors++; $display("[TB] FAIL t4_idle got busy=%b ready=%b exp 0 1", busy, notes_ready); end
  endtask

  task automatic test_stop_midframe();
    bit           to;
    int           wc, sh, gl, fp, quiet;
    logic [N-1:0] w;
    @(negedge clk); enable = 1'b1;
    fork
      capture_frame(1'b0, 0, to, wc, w, sh, gl, fp);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (note_serial_sync === 1'b1) break;
        end
        repeat (20 * D) @(negedge clk);
        enable = 1'b0;
      end
    join
    checks++; if (to !== 1'b0 || w !== y_word) begin errors++; $display("[TB] FAIL t5_word got %h exp %h", w, y_word); end
    checks++; if (gl !== 0 || sh !== D) begin errors++; $display("[TB] FAIL t5_shape got gl=%0d sync=%0d exp 0 %0d", gl, sh, D); end
    checks++; if (fp !== FRAME) begin errors++; $display("[TB] FAIL t5_frame_done got %0d exp %0d", fp, FRAME); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t5_busy got %b exp 0", busy); end
    quiet = 0;
    for (int i = 0; i < 300; i++) begin
      if (note_serial_sync !== 1'b0 || note_serial_data !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) quiet++;
      @(negedge clk);
    end
    checks++; if (quiet !== 0) begin errors++; $display("[TB] FAIL t5_stays_idle got %0d active cycles exp 0", quiet); end
  endtask

  task automatic test_reset_midframe();
    bit           to, found;
    int           wc, sh, gl, fp;
    logic [N-1:0] w;
    z_word = rand48() | 48'h1;
    @(negedge clk); enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (note_serial_sync === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL t6_start got %b exp 1", found); end
    repeat (199) @(negedge clk);
    notes_in = z_word; notes_valid = 1'b1;
    @(negedge clk); notes_valid = 1'b0;
    checks++; if (notes_ready !== 1'b0) begin errors++; $display("[TB] FAIL t6_z_pending got %b exp 0", notes_ready); end
    repeat (30 * D + 64 - 201) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (note_serial_sync !== 1'b0 || note_serial_data !== 1'b0) begin errors++; $display("[TB] FAIL t6_rst_line got sync=%b data=%b exp 0 0", note_serial_sync, note_serial_data); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL t6_rst_busy got busy=%b fd=%b exp 0 0", busy, frame_done); end
    checks++; if (notes_ready !== 1'b1) begin errors++; $display("[TB] FAIL t6_rst_ready got %b exp 1", notes_ready); end
    reset_n = 1'b1;
    capture_frame(1'b0, 0, to, wc, w, sh, gl, fp);
    checks++; if (to !== 1'b0 || w !== '0) begin errors++; $display("[TB] FAIL t6_cleared_word got %h exp 0", w); end
    checks++; if (sh !== D || gl !== 0 || fp !== FRAME) begin errors++; $display("[TB] FAIL t6_restart_shape got sync=%0d gl=%0d fd=%0d exp %0d 0 %0d", sh, gl, fp, D, FRAME); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t6_idle got %b exp 0", busy); end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_single_bit();
    test_pattern();
    test_back_to_back();
    test_stop_midframe();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
